ex_stage: RTL and testbench

Execute stage of the 5-stage RV32I pipeline, sitting directly downstream of the decode stage's ID/EX register and feeding the memory stage.
- Selects forwarded operands and runs the ALU.
- Resolves branches and jumps and produces the redirect to fetch.
- Registers results into the EX/MEM pipeline register.
- Optionally contains an iterative multiply/divide unit that stalls the front of the pipeline while it runs.

---
 rtl/rv_pkg.sv | 44 ++++
 rtl/ex_stage_muldiv_iter.sv | 113 +++++++++++
 rtl/ex_stage.sv | 145 ++++++++++++++
 tb/tb_ex_stage.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared RV32I pipeline definitions: ALU/branch/forward codes, EX/MEM payload
// and the multiply/divide state encoding.
package rv_pkg;

   localparam int unsigned XLEN_W   = 32;
   localparam int unsigned REG_W    = 5;
   localparam int unsigned MD_CNT_W = 5;

   typedef enum logic [3:0] {
      ALU_ADD   = 4'b0000, ALU_SUB  = 4'b0001, ALU_AND  = 4'b0010, ALU_OR   = 4'b0011,
      ALU_XOR   = 4'b0100, ALU_SLT  = 4'b0101, ALU_SLTU = 4'b0110, ALU_SLL  = 4'b0111,
      ALU_SRL   = 4'b1000, ALU_SRA  = 4'b1001, ALU_LUI  = 4'b1010, ALU_AUIPC = 4'b1011,
      ALU_JALR  = 4'b1100, ALU_MUL  = 4'b1101, ALU_DIV  = 4'b1110, ALU_REM  = 4'b1111
   } alu_op_e;

   typedef enum logic [2:0] {
      BR_EQ = 3'b000, BR_NE = 3'b001, BR_LT = 3'b100,
      BR_GE = 3'b101, BR_LTU = 3'b110, BR_GEU = 3'b111
   } br_op_e;

   typedef enum logic [1:0] {
      FWD_REG = 2'b00, FWD_WB = 2'b01, FWD_MEM = 2'b10
   } fwd_sel_e;

   typedef enum logic [1:0] {
      MD_IDLE = 2'b00, MD_RUN = 2'b01, MD_DONE = 2'b10
   } md_state_e;

   typedef struct packed {
      logic [XLEN_W-1:0] alu_result;
      logic [XLEN_W-1:0] write_data;
      logic [XLEN_W-1:0] pc_plus_4;
      logic [REG_W-1:0]  rd;
      logic              regwrite;
      logic              memwrite;
      logic [1:0]        result_src;
   } exmem_t;

   // Codes 1101..1111 are the multi-cycle multiply/divide group.
   function automatic logic is_muldiv(input logic [3:0] op);
      return op[3] & op[2] & (op[1] | op[0]);
   endfunction

endpackage

// File: rtl/ex_stage_muldiv_iter.sv
// Iterative 32-step shift-add multiplier / restoring divider with signed fixup.
// Instantiated by ex_stage only when RV_MULDIV_EN is defined.
module muldiv_iter
   import rv_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              i_start,
   input  logic [3:0]        i_op,
   input  logic [XLEN_W-1:0] i_a,
   input  logic [XLEN_W-1:0] i_b,
   output logic              o_busy_c,
   output logic              o_done_c,
   output logic [XLEN_W-1:0] o_result_c
);

   md_state_e             r_state, w_state_nxt;
   logic [MD_CNT_W-1:0]   r_cnt;
   logic                  r_is_mul, r_is_rem, r_neg_q, r_neg_r, r_b_zero;
   logic [XLEN_W-1:0]     r_a_orig, r_a, r_b, r_acc;
   logic                  w_load, w_step;
   logic [XLEN_W:0]       w_rem_sh, w_diff;
   logic [XLEN_W-1:0]     w_abs_a, w_abs_b, w_q, w_r;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= MD_IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      o_busy_c    = 1'b0;
      o_done_c    = 1'b0;
      w_load      = 1'b0;
      w_step      = 1'b0;
      case (r_state)
         MD_IDLE: if (i_start) begin
            o_busy_c    = 1'b1;
            w_load      = 1'b1;
            w_state_nxt = MD_RUN;
         end
         MD_RUN: begin
            o_busy_c = 1'b1;
            w_step   = 1'b1;
            if (r_cnt == '0) w_state_nxt = MD_DONE;
         end
         MD_DONE: begin
            o_done_c    = 1'b1;
            w_state_nxt = MD_IDLE;
         end
         default: w_state_nxt = MD_IDLE;
      endcase
      // An abandoned operation must release the pipeline while reset is held.
      if (reset) o_busy_c = 1'b0;
   end

   assign w_abs_a  = i_a[XLEN_W-1] ? -i_a : i_a;
   assign w_abs_b  = i_b[XLEN_W-1] ? -i_b : i_b;
   assign w_rem_sh = {r_acc, r_a[XLEN_W-1]};
   assign w_diff   = w_rem_sh - {1'b0, r_b};

   // Multiply: r_a multiplier, r_b shifted multiplicand, r_acc product.
   // Divide:   r_a dividend shifting into quotient, r_b divisor, r_acc remainder.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt    <= '0;
         r_is_mul <= 1'b0;
         r_is_rem <= 1'b0;
         r_neg_q  <= 1'b0;
         r_neg_r  <= 1'b0;
         r_b_zero <= 1'b0;
         r_a_orig <= '0;
         r_a      <= '0;
         r_b      <= '0;
         r_acc    <= '0;
      end else if (w_load) begin
         r_cnt    <= MD_CNT_W'(31);
         r_is_mul <= (i_op == ALU_MUL);
         r_is_rem <= (i_op == ALU_REM);
         r_neg_q  <= i_a[XLEN_W-1] ^ i_b[XLEN_W-1];
         r_neg_r  <= i_a[XLEN_W-1];
         r_b_zero <= (i_b == '0);
         r_a_orig <= i_a;
         r_a      <= (i_op == ALU_MUL) ? i_a : w_abs_a;
         r_b      <= (i_op == ALU_MUL) ? i_b : w_abs_b;
         r_acc    <= '0;
      end else if (w_step) begin
         r_cnt <= r_cnt - MD_CNT_W'(1);
         if (r_is_mul) begin
            if (r_a[0]) r_acc <= r_acc + r_b;
            r_b <= {r_b[XLEN_W-2:0], 1'b0};
            r_a <= {1'b0, r_a[XLEN_W-1:1]};
         end else if (!w_diff[XLEN_W]) begin
            r_acc <= w_diff[XLEN_W-1:0];
            r_a   <= {r_a[XLEN_W-2:0], 1'b1};
         end else begin
            r_acc <= w_rem_sh[XLEN_W-1:0];
            r_a   <= {r_a[XLEN_W-2:0], 1'b0};
         end
      end
   end

   assign w_q = r_neg_q ? -r_a   : r_a;
   assign w_r = r_neg_r ? -r_acc : r_acc;

   always_comb begin
      o_result_c = w_q;
      if (r_is_mul)      o_result_c = r_acc;
      else if (r_b_zero) o_result_c = r_is_rem ? r_a_orig : '1;
      else if (r_is_rem) o_result_c = w_r;
   end

endmodule

// File: rtl/ex_stage.sv
// RV32I execute stage: forwarding, ALU, branch resolution and EX/MEM register.
// Define RV_MULDIV_EN to build in the iterative multiply/divide unit.
module ex_stage
   import rv_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [XLEN-1:0]   rs1_data_e,
   input  logic [XLEN-1:0]   rs2_data_e,
   input  logic [XLEN-1:0]   imm_e,
   input  logic [XLEN-1:0]   pc_e,
   input  logic [XLEN-1:0]   pc_plus_4_e,
   input  logic [4:0]        rd_e,
   input  logic              regwrite_e,
   input  logic              memwrite_e,
   input  logic              jump_e,
   input  logic              branch_e,
   input  logic              alu_src_e,
   input  logic [1:0]        result_src_e,
   input  logic [3:0]        alu_control_e,
   input  logic [2:0]        branch_control_e,
   input  logic [1:0]        forward_a_e,
   input  logic [1:0]        forward_b_e,
   input  logic [XLEN-1:0]   alu_result_fwd_m,
   input  logic [XLEN-1:0]   result_fwd_w,
   output logic              pc_src_e,
   output logic [XLEN-1:0]   pc_target_e,
   output logic              busy_e,
   output logic [XLEN-1:0]   alu_result_m,
   output logic [XLEN-1:0]   write_data_m,
   output logic [XLEN-1:0]   pc_plus_4_m,
   output logic [4:0]        rd_m,
   output logic              regwrite_m,
   output logic              memwrite_m,
   output logic [1:0]        result_src_m
);

   logic [XLEN-1:0] w_srca, w_wdata, w_srcb, w_alu_result;
   logic [XLEN-1:0] w_md_result;
   logic            w_md_busy, w_md_done, w_taken;
   exmem_t          w_exmem, r_exmem;

   always_comb begin
      case (forward_a_e)
         FWD_WB:  w_srca = result_fwd_w;
         FWD_MEM: w_srca = alu_result_fwd_m;
         default: w_srca = rs1_data_e;
      endcase
      case (forward_b_e)
         FWD_WB:  w_wdata = result_fwd_w;
         FWD_MEM: w_wdata = alu_result_fwd_m;
         default: w_wdata = rs2_data_e;
      endcase
   end

   assign w_srcb = alu_src_e ? imm_e : w_wdata;

`ifdef RV_MULDIV_EN
   muldiv_iter u_muldiv (
      .clk        (clk),
      .reset      (reset),
      .i_start    (is_muldiv(alu_control_e)),
      .i_op       (alu_control_e),
      .i_a        (w_srca),
      .i_b        (w_srcb),
      .o_busy_c   (w_md_busy),
      .o_done_c   (w_md_done),
      .o_result_c (w_md_result)
   );
`else
   assign w_md_busy   = 1'b0;
   assign w_md_done   = 1'b0;
   assign w_md_result = '0;
`endif

   assign busy_e = w_md_busy;

   always_comb begin
      w_alu_result = '0;
      case (alu_control_e)
         ALU_ADD:   w_alu_result = w_srca + w_srcb;
         ALU_SUB:   w_alu_result = w_srca - w_srcb;
         ALU_AND:   w_alu_result = w_srca & w_srcb;
         ALU_OR:    w_alu_result = w_srca | w_srcb;
         ALU_XOR:   w_alu_result = w_srca ^ w_srcb;
         ALU_SLT:   w_alu_result = XLEN'($signed(w_srca) < $signed(w_srcb));
         ALU_SLTU:  w_alu_result = XLEN'(w_srca < w_srcb);
         ALU_SLL:   w_alu_result = w_srca << w_srcb[4:0];
         ALU_SRL:   w_alu_result = w_srca >> w_srcb[4:0];
         ALU_SRA:   w_alu_result = XLEN'($signed(w_srca) >>> w_srcb[4:0]);
         ALU_LUI:   w_alu_result = w_srcb;
         ALU_AUIPC: w_alu_result = pc_e + imm_e;
         ALU_JALR:  w_alu_result = w_srca + w_srcb;
         ALU_MUL, ALU_DIV, ALU_REM:
                    w_alu_result = w_md_done ? w_md_result : '0;
         default:   w_alu_result = '0;
      endcase
   end

   always_comb begin
      case (branch_control_e)
         BR_EQ:   w_taken = (w_srca == w_wdata);
         BR_NE:   w_taken = (w_srca != w_wdata);
         BR_LT:   w_taken = ($signed(w_srca) <  $signed(w_wdata));
         BR_GE:   w_taken = ($signed(w_srca) >= $signed(w_wdata));
         BR_LTU:  w_taken = (w_srca <  w_wdata);
         BR_GEU:  w_taken = (w_srca >= w_wdata);
         default: w_taken = 1'b0;
      endcase
   end

   assign pc_src_e    = jump_e | (branch_e & w_taken);
   assign pc_target_e = (alu_control_e == ALU_JALR) ? ((w_srca + imm_e) & ~XLEN'(1))
                                                    : (pc_e + imm_e);

   // A running multi-cycle op is held in EX, so downstream sees bubbles until DONE.
   always_comb begin
      w_exmem = '0;
      if (!w_md_busy) begin
         w_exmem.alu_result = w_alu_result;
         w_exmem.write_data = w_wdata;
         w_exmem.pc_plus_4  = pc_plus_4_e;
         w_exmem.rd         = rd_e;
         w_exmem.regwrite   = regwrite_e;
         w_exmem.memwrite   = memwrite_e;
         w_exmem.result_src = result_src_e;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_exmem <= '0;
      else       r_exmem <= w_exmem;
   end

   assign alu_result_m = r_exmem.alu_result;
   assign write_data_m = r_exmem.write_data;
   assign pc_plus_4_m  = r_exmem.pc_plus_4;
   assign rd_m         = r_exmem.rd;
   assign regwrite_m   = r_exmem.regwrite;
   assign memwrite_m   = r_exmem.memwrite;
   assign result_src_m = r_exmem.result_src;

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage against an arithmetic reference model.
// Multiply/divide sequences are exercised when RV_MULDIV_EN is defined.
module tb_ex_stage;

   logic        clk, reset;
   logic [31:0] rs1_data_e, rs2_data_e, imm_e, pc_e, pc_plus_4_e;
   logic [4:0]  rd_e;
   logic        regwrite_e, memwrite_e, jump_e, branch_e, alu_src_e;
   logic [1:0]  result_src_e;
   logic [3:0]  alu_control_e;
   logic [2:0]  branch_control_e;
   logic [1:0]  forward_a_e, forward_b_e;
   logic [31:0] alu_result_fwd_m, result_fwd_w;
   logic        pc_src_e, busy_e;
   logic [31:0] pc_target_e, alu_result_m, write_data_m, pc_plus_4_m;
   logic [4:0]  rd_m;
   logic        regwrite_m, memwrite_m;
   logic [1:0]  result_src_m;

   int n_assert = 0;
   int n_fail   = 0;

   ex_stage dut (
      .clk(clk), .reset(reset),
      .rs1_data_e(rs1_data_e), .rs2_data_e(rs2_data_e), .imm_e(imm_e), .pc_e(pc_e),
      .pc_plus_4_e(pc_plus_4_e), .rd_e(rd_e), .regwrite_e(regwrite_e),
      .memwrite_e(memwrite_e), .jump_e(jump_e), .branch_e(branch_e),
      .alu_src_e(alu_src_e), .result_src_e(result_src_e), .alu_control_e(alu_control_e),
      .branch_control_e(branch_control_e), .forward_a_e(forward_a_e),
      .forward_b_e(forward_b_e), .alu_result_fwd_m(alu_result_fwd_m),
      .result_fwd_w(result_fwd_w), .pc_src_e(pc_src_e), .pc_target_e(pc_target_e),
      .busy_e(busy_e), .alu_result_m(alu_result_m), .write_data_m(write_data_m),
      .pc_plus_4_m(pc_plus_4_m), .rd_m(rd_m), .regwrite_m(regwrite_m),
      .memwrite_m(memwrite_m), .result_src_m(result_src_m)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] ref_fwd(input logic [1:0] s, input logic [31:0] r,
                                           input logic [31:0] w, input logic [31:0] m);
      if (s == 2'b01) return w;
      if (s == 2'b10) return m;
      return r;
   endfunction

   function automatic logic [31:0] ref_alu(input int op, input logic [31:0] a,
                                           input logic [31:0] b, input logic [31:0] pc,
                                           input logic [31:0] imm);
      logic [4:0] sh;
      int sa, sb;
      sh = b[4:0];
      sa = a;
      sb = b;
      case (op)
         0:  return a + b;
         1:  return a - b;
         2:  return a & b;
         3:  return a | b;
         4:  return a ^ b;
         5:  return (sa < sb) ? 32'd1 : 32'd0;
         6:  return (a < b) ? 32'd1 : 32'd0;
         7:  return a << sh;
         8:  return a >> sh;
         9:  return 32'(sa >>> sh);
         10: return b;
         11: return pc + imm;
         12: return a + b;
`ifdef RV_MULDIV_EN
         13: return 32'(longint'(a) * longint'(b));
         14: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
            return 32'(sa / sb);
         end
         15: begin
            if (b == 0) return a;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
            return 32'(sa % sb);
         end
`endif
         default: return 32'd0;
      endcase
   endfunction

   function automatic logic ref_taken(input logic [2:0] bc, input logic [31:0] a,
                                      input logic [31:0] b);
      int sa, sb;
      sa = a;
      sb = b;
      case (bc)
         3'd0: return a == b;
         3'd1: return a != b;
         3'd4: return sa < sb;
         3'd5: return sa >= sb;
         3'd6: return a < b;
         3'd7: return a >= b;
         default: return 1'b0;
      endcase
   endfunction

   // Single-cycle instruction: combinational redirect now, EX/MEM after one edge.
   task automatic step_check(input string tag);
      logic [31:0] a, wd, b, e_res, e_tgt;
      logic        e_src;
      a     = ref_fwd(forward_a_e, rs1_data_e, result_fwd_w, alu_result_fwd_m);
      wd    = ref_fwd(forward_b_e, rs2_data_e, result_fwd_w, alu_result_fwd_m);
      b     = alu_src_e ? imm_e : wd;
      e_res = ref_alu(int'(alu_control_e), a, b, pc_e, imm_e);
      e_src = jump_e | (branch_e & ref_taken(branch_control_e, a, wd));
      e_tgt = (alu_control_e == 4'd12) ? ((a + imm_e) & 32'hFFFF_FFFE) : (pc_e + imm_e);
      #1;
      chk({tag, " pc_src_e"}, 32'(pc_src_e), 32'(e_src));
      chk({tag, " pc_target_e"}, pc_target_e, e_tgt);
      chk({tag, " busy_e"}, 32'(busy_e), 32'd0);
      @(posedge clk); #1;
      chk({tag, " alu_result_m"}, alu_result_m, e_res);
      chk({tag, " write_data_m"}, write_data_m, wd);
      chk({tag, " pc_plus_4_m"}, pc_plus_4_m, pc_plus_4_e);
      chk({tag, " ctrl_m"}, {21'd0, rd_m, regwrite_m, memwrite_m, result_src_m, 2'd0},
          {21'd0, rd_e, regwrite_e, memwrite_e, result_src_e, 2'd0});
   endtask

   task automatic set_plain();
      jump_e = 1'b0; branch_e = 1'b0; alu_src_e = 1'b0; memwrite_e = 1'b0;
      forward_a_e = 2'b00; forward_b_e = 2'b00; branch_control_e = 3'd2;
      result_src_e = 2'd0; regwrite_e = 1'b1;
   endtask

`ifdef RV_MULDIV_EN
   // Multi-cycle op: busy cycles 0..32 with bubbles, result captured after cycle 33.
   task automatic md_check(input string tag, input logic [3:0] op,
                           input logic [31:0] a, input logic [31:0] b);
      logic [31:0] e_res;
      set_plain();
      alu_control_e = op; forward_a_e = 2'b10; alu_result_fwd_m = a;
      rs2_data_e = b; rd_e = 5'd9; pc_plus_4_e = 32'h44;
      e_res = ref_alu(int'(op), a, b, pc_e, imm_e);
      for (int c = 0; c <= 33; c++) begin
         #1;
         chk({tag, " busy_e"}, 32'(busy_e), (c <= 32) ? 32'd1 : 32'd0);
         if (c == 5) alu_result_fwd_m = ~a;
         @(posedge clk); #1;
         if (c <= 32) begin
            chk({tag, " bubble alu_result_m"}, alu_result_m, 32'd0);
            chk({tag, " bubble regwrite_m"}, 32'(regwrite_m), 32'd0);
         end else begin
            chk({tag, " alu_result_m"}, alu_result_m, e_res);
            chk({tag, " regwrite_m"}, 32'(regwrite_m), 32'd1);
            chk({tag, " rd_m"}, 32'(rd_m), 32'd9);
         end
      end
   endtask
`endif

   initial begin
      reset = 1'b1;
      rs1_data_e = 32'd5; rs2_data_e = 32'd6; imm_e = 32'd0; pc_e = 32'd0;
      pc_plus_4_e = 32'd4; rd_e = 5'd3; alu_result_fwd_m = 32'd0; result_fwd_w = 32'd0;
      alu_control_e = 4'd0;
      set_plain();
      memwrite_e = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("reset alu_result_m", alu_result_m, 32'd0);
      chk("reset write_data_m", write_data_m, 32'd0);
      chk("reset pc_plus_4_m", pc_plus_4_m, 32'd0);
      chk("reset ctrl_m", {rd_m, regwrite_m, memwrite_m, result_src_m}, 32'd0);
      chk("reset busy_e", 32'(busy_e), 32'd0);
      reset = 1'b0;

      // ADD with MEM forwarding and immediate operand
      set_plain();
      alu_control_e = 4'd0; forward_a_e = 2'b10; alu_result_fwd_m = 32'd5;
      alu_src_e = 1'b1; imm_e = 32'd3; rd_e = 5'd7;
      step_check("add_fwd");
      chk("add_fwd const", alu_result_m, 32'd8);

      // BLT taken with -1 < 1
      set_plain();
      regwrite_e = 1'b0; branch_e = 1'b1; branch_control_e = 3'd4;
      rs1_data_e = 32'hFFFF_FFFF; rs2_data_e = 32'd1; pc_e = 32'h100; imm_e = 32'h20;
      alu_control_e = 4'd1;
      #1;
      chk("blt const pc_src_e", 32'(pc_src_e), 32'd1);
      chk("blt const pc_target_e", pc_target_e, 32'h120);
      step_check("blt");

      // JALR clears bit 0 of the target
      set_plain();
      jump_e = 1'b1; alu_src_e = 1'b1; alu_control_e = 4'd12;
      rs1_data_e = 32'h203; imm_e = 32'd0; pc_plus_4_e = 32'h1234_5678; result_src_e = 2'd2;
      #1;
      chk("jalr const pc_target_e", pc_target_e, 32'h202);
      step_check("jalr");

      // WB forwarding on B, select 11 falls back to register data
      set_plain();
      alu_control_e = 4'd9; forward_a_e = 2'b11; forward_b_e = 2'b01;
      rs1_data_e = 32'h8000_0010; result_fwd_w = 32'd31;
      step_check("sra_fwd");

      for (int i = 0; i < 80; i++) begin
`ifdef RV_MULDIV_EN
         alu_control_e = 4'($urandom_range(0, 12));
`else
         alu_control_e = 4'($urandom_range(0, 15));
`endif
         rs1_data_e = $urandom; rs2_data_e = (i % 4 == 0) ? rs1_data_e : $urandom;
         imm_e = $urandom; pc_e = $urandom; pc_plus_4_e = $urandom;
         alu_result_fwd_m = $urandom; result_fwd_w = $urandom;
         forward_a_e = 2'($urandom_range(0, 3)); forward_b_e = 2'($urandom_range(0, 3));
         alu_src_e = 1'($urandom); branch_e = 1'($urandom); jump_e = 1'($urandom_range(0, 3) == 0);
         branch_control_e = 3'($urandom); regwrite_e = 1'($urandom); memwrite_e = 1'($urandom);
         result_src_e = 2'($urandom); rd_e = 5'($urandom);
         step_check("random");
      end

`ifdef RV_MULDIV_EN
      md_check("div -7/2", 4'd14, 32'hFFFF_FFF9, 32'd2);
      chk("div -7/2 const", alu_result_m, 32'hFFFF_FFFD);
      md_check("rem -7/2", 4'd15, 32'hFFFF_FFF9, 32'd2);
      chk("rem -7/2 const", alu_result_m, 32'hFFFF_FFFF);
      md_check("div by 0", 4'd14, 32'h1234_5678, 32'd0);
      md_check("rem by 0", 4'd15, 32'h8765_4321, 32'd0);
      md_check("div ovf", 4'd14, 32'h8000_0000, 32'hFFFF_FFFF);
      md_check("rem ovf", 4'd15, 32'h8000_0000, 32'hFFFF_FFFF);
      for (int i = 0; i < 6; i++)
         md_check("random muldiv", 4'($urandom_range(13, 15)), $urandom, $urandom);
      md_check("mul neg", 4'd13, 32'hFFFF_FFFD, 32'd7);
`else
      set_plain();
      for (int op = 13; op <= 15; op++) begin
         alu_control_e = 4'(op); rs1_data_e = $urandom; rs2_data_e = $urandom;
         step_check("muldiv disabled");
      end
`endif

      // Reset in the middle of a MUL abandons it without writeback
      set_plain();
      alu_control_e = 4'd13; rs1_data_e = 32'd123; rs2_data_e = 32'd456; rd_e = 5'd11;
      repeat (10) @(posedge clk);
      #1;
      reset = 1'b1;
      #1;
      chk("midreset busy_e", 32'(busy_e), 32'd0);
      chk("midreset alu_result_m", alu_result_m, 32'd0);
      chk("midreset ctrl_m", {rd_m, regwrite_m, memwrite_m, result_src_m}, 32'd0);
      alu_control_e = 4'd0; regwrite_e = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0;
      for (int c = 0; c < 40; c++) begin
         @(posedge clk); #1;
         chk("post-reset busy_e", 32'(busy_e), 32'd0);
         chk("post-reset regwrite_m", 32'(regwrite_m), 32'd0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
